// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control unit: fetch/decode, A/D/PC, data-memory handshakes, external ALU drive.
// Define HACK_HALT_EN to detect self-jump loops and park in a HALT state.
module hack_cpu_ctrl #(
  parameter int            W        = 16,
  parameter int            AW       = 15,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [AW-1:0] pc,
  output logic [5:0]    c,
  output logic [W-1:0]  x,
  output logic [W-1:0]  y,
  input  logic [W-1:0]  alu_out,
  input  logic          zr,
  input  logic          ng,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [W-1:0]  mem_wdata,
  input  logic [W-1:0]  mem_rdata,
  input  logic          mem_rvalid,
  input  logic          mem_wready,
  output logic [W-1:0]  a_reg,
  output logic [W-1:0]  d_reg,
  output logic          halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM_RD = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM_WR = 3'd4
`ifdef HACK_HALT_EN
    , S_HALT = 3'd5
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, pc_pend_q, pc_pend_d, maddr_q, maddr_d;
  logic [W-1:0]  areg_q, areg_d, dreg_q, dreg_d, mreg_q, mreg_d;
  logic [W-1:0]  ir_q, ir_d, wdata_q, wdata_d;
  logic [AW-1:0] pc_inc_s, pc_tgt_s, pc_exec_s;
  logic          jump_s;

  assign pc_inc_s  = pc_q + AW'(1);
  // Jump target is the A value from before this EXEC's own A write.
  assign pc_tgt_s  = areg_q[AW-1:0];
  assign jump_s    = (ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~ng & ~zr);
  assign pc_exec_s = jump_s ? pc_tgt_s : pc_inc_s;

`ifdef HACK_HALT_EN
  logic prev_a_q, prev_a_d, halted_q, halted_d, halt_s;
  assign halt_s = jump_s && ((pc_tgt_s == pc_q) ||
                             (prev_a_q && (pc_tgt_s == (pc_q - AW'(1)))));
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign pc        = pc_q;
  assign x         = dreg_q;
  assign y         = ir_q[12] ? mreg_q : areg_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;
  assign a_reg     = areg_q;
  assign d_reg     = dreg_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_pend_d   = pc_pend_q;
    maddr_d     = maddr_q;
    areg_d      = areg_q;
    dreg_d      = dreg_q;
    mreg_d      = mreg_q;
    ir_d        = ir_q;
    wdata_d     = wdata_q;
`ifdef HACK_HALT_EN
    prev_a_d    = prev_a_q;
    halted_d    = halted_q;
`endif
    instr_ready = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    c           = 6'b101010;
    case (state_q)
      S_FETCH: begin
        instr_ready = ~reset;
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (!ir_q[15]) begin
          areg_d  = W'(ir_q[14:0]);
          pc_d    = pc_inc_s;
          state_d = S_FETCH;
`ifdef HACK_HALT_EN
          prev_a_d = 1'b1;
`endif
        end else begin
          maddr_d = areg_q[AW-1:0];
          state_d = ir_q[12] ? S_MEM_RD : S_EXEC;
        end
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        if (mem_rvalid) begin
          mreg_d  = mem_rdata;
          state_d = S_EXEC;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_EXEC: begin
        c = ir_q[11:6];
        if (ir_q[5]) areg_d = alu_out; else areg_d = areg_q;
        if (ir_q[4]) dreg_d = alu_out; else dreg_d = dreg_q;
        // With a memory write pending, the PC update waits for the write to complete.
        if (ir_q[3]) begin
          wdata_d   = alu_out;
          pc_pend_d = pc_exec_s;
          state_d   = S_MEM_WR;
        end else begin
          pc_d    = pc_exec_s;
          state_d = S_FETCH;
        end
`ifdef HACK_HALT_EN
        prev_a_d = 1'b0;
        if (halt_s) begin
          halted_d = 1'b1;
          pc_d     = pc_q;
          state_d  = S_HALT;
        end else begin
          halted_d = halted_q;
        end
`endif
      end
      S_MEM_WR: begin
        mem_wr = 1'b1;
        if (mem_wready) begin
          pc_d    = pc_pend_q;
          state_d = S_FETCH;
        end else begin
          state_d = S_MEM_WR;
        end
      end
`ifdef HACK_HALT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      pc_pend_q <= '0;
      maddr_q   <= '0;
      areg_q    <= '0;
      dreg_q    <= '0;
      mreg_q    <= '0;
      ir_q      <= '0;
      wdata_q   <= '0;
`ifdef HACK_HALT_EN
      prev_a_q  <= 1'b0;
      halted_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_pend_q <= pc_pend_d;
      maddr_q   <= maddr_d;
      areg_q    <= areg_d;
      dreg_q    <= dreg_d;
      mreg_q    <= mreg_d;
      ir_q      <= ir_d;
      wdata_q   <= wdata_d;
`ifdef HACK_HALT_EN
      prev_a_q  <= prev_a_d;
      halted_q  <= halted_d;
`endif
    end
  end

endmodule
